// File: rtl/s32x_sdr_arb_pkg.sv
// s32x_sdr_arb_pkg: shared types for the 32X SDRAM arbiter.
package s32x_sdr_arb_pkg;

    localparam int SDR_AW = 17;

    typedef struct packed {
        logic [SDR_AW-1:0] a;
        logic [15:0]       d;
        logic [1:0]        we;
        logic              rd;
    } sdr_req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} sdr_arb_state_t;

    localparam logic [1:0] OWN_M = 2'b01;
    localparam logic [1:0] OWN_S = 2'b10;

endpackage

// File: rtl/s32x_sdr_arb_pick.sv
// s32x_sdr_arb_pick: winner selection between master and slave SH2 requests.
// S32X_SDR_ARB_FIXED_PRIO_EN selects master priority with a starvation limit; default is round-robin.
module s32x_sdr_arb_pick
    import s32x_sdr_arb_pkg::*;
`ifdef S32X_SDR_ARB_FIXED_PRIO_EN
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CW           = 2
)
`endif
(
    input  logic          req_m,
    input  logic          req_s,
`ifdef S32X_SDR_ARB_FIXED_PRIO_EN
    input  logic [CW-1:0] starve_cnt,
`else
    input  logic [1:0]    last,
`endif
    output logic [1:0]    win
);

`ifdef S32X_SDR_ARB_FIXED_PRIO_EN
    always_comb begin
        win = (req_m & req_s) ? (starve_cnt == CW'(STARVE_LIMIT) ? OWN_S : OWN_M)
            : req_m ? OWN_M : req_s ? OWN_S : 2'b00;
    end
`else
    always_comb begin
        win = (req_m & req_s) ? (last == OWN_S ? OWN_M : OWN_S)
            : req_m ? OWN_M : req_s ? OWN_S : 2'b00;
    end
`endif

endmodule

// File: rtl/s32x_sdr_arb.sv
// s32x_sdr_arb: arbitrates master/slave SH2 CS3 accesses onto the single 32X SDRAM port.
// Define S32X_SDR_ARB_FIXED_PRIO_EN for master priority with a slave starvation limit.
module s32x_sdr_arb
    import s32x_sdr_arb_pkg::*;
#(
    parameter int AW           = 17,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          M_CS,
    input  logic [AW-1:0] M_A,
    input  logic [15:0]   M_DO,
    input  logic [1:0]    M_WE,
    input  logic          M_RD,
    output logic [15:0]   M_DI,
    output logic          M_WAIT,
    input  logic          S_CS,
    input  logic [AW-1:0] S_A,
    input  logic [15:0]   S_DO,
    input  logic [1:0]    S_WE,
    input  logic          S_RD,
    output logic [15:0]   S_DI,
    output logic          S_WAIT,
    output logic [AW-1:0] SDR_A,
    output logic [15:0]   SDR_DO,
    output logic          SDR_CS,
    output logic [1:0]    SDR_WE,
    output logic          SDR_RD,
    input  logic [15:0]   SDR_DI,
    input  logic          SDR_WAIT,
    output logic [1:0]    GNT
);

    sdr_arb_state_t state, nxt;
    sdr_req_t       req_r;
    logic [1:0]     gnt_r, last, win;
    logic           done_m, done_s, req_m, req_s, fin;

    assign req_m  = M_CS & (M_RD | |M_WE) & ~done_m;
    assign req_s  = S_CS & (S_RD | |S_WE) & ~done_s;
    assign M_WAIT = M_CS & ~done_m;
    assign S_WAIT = S_CS & ~done_s;
    assign fin    = (state == ACCESS) & ~SDR_WAIT;
    assign GNT    = gnt_r;
    assign SDR_A  = AW'(req_r.a);
    assign SDR_DO = req_r.d;

`ifdef S32X_SDR_ARB_FIXED_PRIO_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            starve_cnt <= '0;
        else if (state == IDLE && |win)
            starve_cnt <= (win == OWN_M && req_s) ? starve_cnt + CW'(1) : '0;
    end

    s32x_sdr_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) u_pick (
        .req_m      (req_m),
        .req_s      (req_s),
        .starve_cnt (starve_cnt),
        .win        (win)
    );
`else
    s32x_sdr_arb_pick u_pick (
        .req_m (req_m),
        .req_s (req_s),
        .last  (last),
        .win   (win)
    );
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt    = state;
        SDR_CS = 1'b0;
        SDR_WE = 2'b00;
        SDR_RD = 1'b0;
        if (state == IDLE && |win)
            nxt = ACCESS;
        if (state == ACCESS) begin
            SDR_CS = 1'b1;
            SDR_WE = req_r.we;
            SDR_RD = req_r.rd;
            if (fin)
                nxt = RESP;
        end
        if (state == RESP)
            nxt = IDLE;
    end

    // done_x only latches if the owner still holds CS at completion; any CS-low cycle clears it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_r  <= '0;
            gnt_r  <= 2'b00;
            last   <= OWN_S;
            done_m <= 1'b0;
            done_s <= 1'b0;
            M_DI   <= '0;
            S_DI   <= '0;
        end else begin
            if (state == IDLE && |win) begin
                req_r <= (win == OWN_M) ? {SDR_AW'(M_A), M_DO, M_WE, M_RD & ~|M_WE}
                                        : {SDR_AW'(S_A), S_DO, S_WE, S_RD & ~|S_WE};
                gnt_r <= win;
                last  <= win;
            end
            if (fin)
                gnt_r <= 2'b00;
            if (fin && req_r.rd && gnt_r == OWN_M)
                M_DI <= SDR_DI;
            if (fin && req_r.rd && gnt_r == OWN_S)
                S_DI <= SDR_DI;
            done_m <= M_CS & (done_m | (fin & (gnt_r == OWN_M)));
            done_s <= S_CS & (done_s | (fin & (gnt_r == OWN_S)));
        end
    end

endmodule

// File: tb/tb_s32x_sdr_arb.sv
// tb_s32x_sdr_arb: scoreboard bench for the 32X SDRAM arbiter; expected SDR transactions and
// CPU read data are queued at stimulus time and checked by an independent monitor.
module tb_s32x_sdr_arb;

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] d;
        logic [1:0]  we;
        logic        rd;
        logic [1:0]  gnt;
    } exp_t;

    logic        CLK, RST;
    logic        M_CS, M_RD, S_CS, S_RD, SDR_WAIT;
    logic [16:0] M_A, S_A;
    logic [15:0] M_DO, S_DO, SDR_DI;
    logic [1:0]  M_WE, S_WE;
    logic [15:0] M_DI, S_DI, SDR_DO;
    logic        M_WAIT, S_WAIT, SDR_CS, SDR_RD;
    logic [16:0] SDR_A;
    logic [1:0]  SDR_WE, GNT;

    exp_t        sdr_q[$];
    logic [15:0] m_q[$];
    logic [15:0] s_q[$];
    exp_t        e_mon;
    logic [1:0]  pend;
    int          n_chk, n_fail;

    s32x_sdr_arb dut (
        .CLK(CLK), .RST(RST),
        .M_CS(M_CS), .M_A(M_A), .M_DO(M_DO), .M_WE(M_WE), .M_RD(M_RD), .M_DI(M_DI), .M_WAIT(M_WAIT),
        .S_CS(S_CS), .S_A(S_A), .S_DO(S_DO), .S_WE(S_WE), .S_RD(S_RD), .S_DI(S_DI), .S_WAIT(S_WAIT),
        .SDR_A(SDR_A), .SDR_DO(SDR_DO), .SDR_CS(SDR_CS), .SDR_WE(SDR_WE), .SDR_RD(SDR_RD),
        .SDR_DI(SDR_DI), .SDR_WAIT(SDR_WAIT), .GNT(GNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_sdr(input logic [16:0] a, input logic [15:0] d, input logic [1:0] we,
                            input logic rd, input logic [1:0] g);
        sdr_q.push_back({a, d, we, rd, g});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        {M_CS, M_RD, M_WE, M_A, M_DO} = '0;
        {S_CS, S_RD, S_WE, S_A, S_DO} = '0;
        SDR_WAIT = 1'b0;
        SDR_DI   = '0;
        repeat (2) step();
        RST = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((sdr_q.size() != 0 || m_q.size() != 0 || s_q.size() != 0 || pend != 0) && t < budget) begin
            step();
            t++;
        end
        chk("drain", sdr_q.size() + m_q.size() + s_q.size(), 0);
    endtask

    task automatic drive_m(input int n);
        for (int i = 0; i < n; i++) begin
            M_A = 17'(32'h200 + i); M_DO = 16'(32'h1000 + i); M_WE = 2'b11; M_RD = 1'b0; M_CS = 1'b1;
            for (int t = 0; t < 40; t++) begin
                step();
                if (!M_WAIT) break;
            end
            M_CS = 1'b0;
            step();
        end
    endtask

    task automatic drive_s(input int n);
        for (int i = 0; i < n; i++) begin
            S_A = 17'(32'h300 + i); S_DO = 16'(32'h2000 + i); S_WE = 2'b10; S_RD = 1'b0; S_CS = 1'b1;
            for (int t = 0; t < 40; t++) begin
                step();
                if (!S_WAIT) break;
            end
            S_CS = 1'b0;
            step();
        end
    endtask

    // Monitor: SDR completions pop the transaction queue; the following RESP cycle checks the owner.
    always @(negedge CLK) begin
        if (RST) begin
            pend = 2'b00;
        end else begin
            if (pend != 2'b00) begin
                chk("resp_gnt", GNT, 2'b00);
                chk("resp_cs", SDR_CS, 1'b0);
                if (pend == 2'b01) begin
                    chk("m_wait_done", M_WAIT, 1'b0);
                    if (m_q.size() == 0) chk("m_unexpected", 1, 0);
                    else chk("m_di", M_DI, m_q.pop_front());
                end else begin
                    chk("s_wait_done", S_WAIT, 1'b0);
                    if (s_q.size() == 0) chk("s_unexpected", 1, 0);
                    else chk("s_di", S_DI, s_q.pop_front());
                end
                pend = 2'b00;
            end
            if (SDR_CS && !SDR_WAIT) begin
                if (sdr_q.size() == 0) begin
                    chk("sdr_unexpected", 1, 0);
                end else begin
                    e_mon = sdr_q.pop_front();
                    chk("sdr_a", SDR_A, e_mon.a);
                    chk("sdr_do", SDR_DO, e_mon.d);
                    chk("sdr_we", SDR_WE, e_mon.we);
                    chk("sdr_rd", SDR_RD, e_mon.rd);
                    chk("sdr_gnt", GNT, e_mon.gnt);
                end
                pend = GNT;
            end
        end
    end

    initial begin
        logic [7:0] seq;
        int mi, si;
        n_chk = 0; n_fail = 0; pend = 2'b00;
        RST = 1'b1;
        do_reset();
        RST = 1'b1;
        #1;
        chk("rst_sdr_cs", SDR_CS, 0);
        chk("rst_gnt", GNT, 0);
        chk("rst_sdr_we", SDR_WE, 0);
        chk("rst_sdr_rd", SDR_RD, 0);
        chk("rst_sdr_a", SDR_A, 0);
        chk("rst_sdr_do", SDR_DO, 0);
        chk("rst_m_di", M_DI, 0);
        chk("rst_s_di", S_DI, 0);
        do_reset();

        // Master read, zero wait: latency and hold-after-completion
        M_A = 17'h00100; M_RD = 1'b1; SDR_DI = 16'h1234; M_CS = 1'b1;
        push_sdr(17'h00100, 16'h0000, 2'b00, 1'b1, 2'b01);
        m_q.push_back(16'h1234);
        @(negedge CLK);
        chk("c0_sdr_cs", SDR_CS, 0);
        chk("c0_m_wait", M_WAIT, 1);
        @(negedge CLK);
        chk("c1_sdr_cs", SDR_CS, 1);
        chk("c1_gnt", GNT, 2'b01);
        chk("c1_s_wait", S_WAIT, 0);
        @(negedge CLK);
        chk("c2_m_wait", M_WAIT, 0);
        chk("c2_s_wait", S_WAIT, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("hold_m_wait", M_WAIT, 0);
            chk("hold_sdr_cs", SDR_CS, 0);
        end
        step();
        M_CS = 1'b0;
        step();
        M_A = 17'h00101; SDR_DI = 16'h4321; M_CS = 1'b1;
        push_sdr(17'h00101, 16'h0000, 2'b00, 1'b1, 2'b01);
        m_q.push_back(16'h4321);
        drain(20);
        M_CS = 1'b0; M_RD = 1'b0;
        step();

        // Simultaneous writes after reset: master first, slave second
        do_reset();
        M_A = 17'h00A00; M_DO = 16'hAAAA; M_WE = 2'b11; M_CS = 1'b1;
        S_A = 17'h00B00; S_DO = 16'h5555; S_WE = 2'b01; S_CS = 1'b1;
        push_sdr(17'h00A00, 16'hAAAA, 2'b11, 1'b0, 2'b01);
        push_sdr(17'h00B00, 16'h5555, 2'b01, 1'b0, 2'b10);
        m_q.push_back(16'h0000);
        s_q.push_back(16'h0000);
        drain(30);
        M_CS = 1'b0; S_CS = 1'b0; M_WE = 2'b00; S_WE = 2'b00;
        step();

        // Slave read stretched by SDR_WAIT for five ACCESS cycles
        SDR_WAIT = 1'b1; SDR_DI = 16'hDEA0;
        S_A = 17'h1ABCD; S_DO = 16'h0BAD; S_RD = 1'b1; S_CS = 1'b1;
        push_sdr(17'h1ABCD, 16'h0BAD, 2'b00, 1'b1, 2'b10);
        s_q.push_back(16'hBEEF);
        @(negedge CLK);
        for (int t = 0; t < 10 && !SDR_CS; t++) @(negedge CLK);
        chk("s_cs_seen", SDR_CS, 1);
        for (int i = 0; i < 5; i++) begin
            chk("s_wait_hold", S_WAIT, 1);
            step();
            if (i == 4) begin
                SDR_WAIT = 1'b0;
                SDR_DI   = 16'hBEEF;
            end else begin
                SDR_DI = 16'(32'hDEA1 + i);
            end
            if (i < 4) @(negedge CLK);
        end
        drain(20);
        S_CS = 1'b0; S_RD = 1'b0;
        step();

        // Reset in the middle of an access, then reissue
        do_reset();
        SDR_WAIT = 1'b1;
        M_A = 17'h00F00; M_RD = 1'b1; M_CS = 1'b1;
        @(negedge CLK);
        for (int t = 0; t < 10 && !SDR_CS; t++) @(negedge CLK);
        chk("r_cs_seen", SDR_CS, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("r_async_cs", SDR_CS, 0);
        chk("r_async_gnt", GNT, 0);
        step();
        push_sdr(17'h00F00, 16'h0000, 2'b00, 1'b1, 2'b01);
        m_q.push_back(16'h7777);
        SDR_DI = 16'h7777; SDR_WAIT = 1'b0; RST = 1'b0;
        drain(20);
        M_CS = 1'b0; M_RD = 1'b0;
        step();

        // Continuous contention: grant order depends on the build's policy
        do_reset();
`ifdef S32X_SDR_ARB_FIXED_PRIO_EN
        seq = 8'b1000_1000;
`else
        seq = 8'b1010_1010;
`endif
        mi = 0; si = 0;
        for (int i = 0; i < 8; i++) begin
            if (seq[i]) begin
                push_sdr(17'(32'h300 + si), 16'(32'h2000 + si), 2'b10, 1'b0, 2'b10);
                s_q.push_back(16'h0000);
                si++;
            end else begin
                push_sdr(17'(32'h200 + mi), 16'(32'h1000 + mi), 2'b11, 1'b0, 2'b01);
                m_q.push_back(16'h0000);
                mi++;
            end
        end
        fork
            drive_m(mi);
            drive_s(si);
        join
        drain(20);
        chk("final_sdr_q", sdr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
